cmp_frame_stats: RTL and testbench
==================================

Name: cmp_frame_stats

Overview:
- Streaming statistics stage that sits directly downstream of the N-bit magnitude comparator.
- Accepts framed unsigned samples over a valid/ready handshake and compares each one against a per-frame threshold (eq/lt/gt) and against the running min/max.
- After the last beat of a frame, presents one result record: min, max, eq/lt/gt tallies, and beat count.

Parameters:
N, 16, sample and threshold width in bits (unsigned).
CNT_W, 16, width of every tally/count register.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  sample beat valid.
in_ready  output  1  stage can accept a beat.
in_data  input  N  unsigned sample.
in_last  input  1  marks final beat of frame.
thresh  input  N  threshold; sampled on the first accepted beat of each frame.
out_valid  output  1  result record valid.
out_ready  input  1  downstream accepts record.
out_min  output  N  smallest sample in frame.
out_max  output  N  largest sample in frame.
out_cnt_eq  output  CNT_W  beats with sample == threshold.
out_cnt_lt  output  CNT_W  beats with sample < threshold.
out_cnt_gt  output  CNT_W  beats with sample > threshold.
out_count  output  CNT_W  total beats in frame.
out_sat  output  1  at least one counter saturated during frame.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; out_valid = 0.
  - All out_* data registers = 0; out_sat = 0.
  - in_ready = 1 from the first clock edge after reset deasserts.
- Handshake rules:
  - A beat is accepted when in_valid & in_ready on a rising edge.
  - A record is consumed when out_valid & out_ready on a rising edge.
  - in_ready = 1 in IDLE and ACCUM, 0 in REPORT. in_ready is combinational from state only, never from in_valid.
- State IDLE:
  - On an accepted beat: latch thresh; min = max = in_data.
  - count = 1; exactly one of eq/lt/gt = 1 per the compare against the live thresh; sat = 0.
  - in_last = 1 -> REPORT, else -> ACCUM.
- State ACCUM:
  - On an accepted beat, compare in_data against the latched thresh. Increment exactly one of eq/lt/gt and increment count.
  - min = in_data if in_data < min. max = in_data if in_data > max.
  - in_last -> REPORT. Cycles with no beat hold all state.
- State REPORT:
  - out_valid = 1, and all out_* reflect the finished frame, from the first cycle after the in_last beat is accepted (latency 1 cycle).
  - Record held stable while out_valid & !out_ready.
  - On consume -> IDLE. out_valid drops the next cycle; data outputs keep their last values.
- Throughput:
  - Minimum 1 idle cycle on the input between frames (the REPORT cycle).
  - Back-to-back frames require out_ready high in REPORT.
- Arithmetic:
  - All compares are unsigned N-bit.
  - Counters saturate at 2^CNT_W-1 and never wrap. Any attempted increment past max sets sat (sticky until next frame start).
- Single-beat frame (first beat has in_last = 1): min = max = that sample, count = 1, goes straight IDLE -> REPORT.
- thresh changing mid-frame has no effect on the current frame.
- in_data/in_last are ignored when in_ready = 0.
- Reset asserted mid-frame or in REPORT: the frame is discarded and all outputs go to their reset values immediately.
- Outputs are registered; there is no combinational path from any input to out_*.

Test Plan:
- Reset behaviour: assert rst mid-frame after 3 beats -> out_valid = 0 and all out_* = 0 immediately. After release, new frame {5} with thresh = 5 -> record min = 5, max = 5, eq = 1, lt = 0, gt = 0, count = 1.
- Basic frame, thresh = 100, beats {100, 20, 300, 100, 65535 (last)}:
  - Record min = 20, max = 65535, eq = 2, lt = 1, gt = 2, count = 5.
  - out_valid rises exactly 1 cycle after the last beat.
- Backpressure: hold out_ready = 0 for 10 cycles in REPORT -> record stable and in_ready = 0 throughout. Release -> IDLE one cycle later.
- Threshold latch: thresh = 50 at first beat, switched to 0 mid-frame. Beats {50, 60, 40 (last)} -> eq = 1, gt = 1, lt = 1.
- Saturation (CNT_W = 4): 20 beats all equal to thresh -> eq = 15, count = 15, out_sat = 1. Next frame of 2 beats -> out_sat = 0, count = 2.
- Gapped input: in_valid toggling randomly, beats {0, 0xFFFF, 7 (last)}, thresh = 0 -> min = 0, max = 65535, eq = 1, gt = 2, count = 3.

Source files
------------

// File: rtl/cmp_frame_stats_if.sv
// ============================================================================
// Module   : cmp_frame_stats_if
// Purpose  : Sample-in / record-out bundle for the frame statistics stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmp_frame_stats_if #(
  parameter int N     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic [N-1:0]     thresh;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_min;
  logic [N-1:0]     out_max;
  logic [CNT_W-1:0] out_cnt_eq;
  logic [CNT_W-1:0] out_cnt_lt;
  logic [CNT_W-1:0] out_cnt_gt;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport master (
    output in_valid, in_data, in_last, thresh, out_ready,
    input  in_ready, out_valid, out_min, out_max,
           out_cnt_eq, out_cnt_lt, out_cnt_gt, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, thresh, out_ready,
    output in_ready, out_valid, out_min, out_max,
           out_cnt_eq, out_cnt_lt, out_cnt_gt, out_count, out_sat
  );
endinterface

`default_nettype wire

// File: rtl/cmp_frame_stats.sv
// ============================================================================
// Module   : cmp_frame_stats
// Purpose  : Per-frame min/max and threshold eq/lt/gt tallies over a stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_frame_stats #(
  parameter int N     = 16,
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  cmp_frame_stats_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [N-1:0]     thr_q, thr_d;
  logic [N-1:0]     min_q, min_d;
  logic [N-1:0]     max_q, max_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             out_valid_q;
  logic [N-1:0]     out_min_q, out_max_q;
  logic [CNT_W-1:0] out_eq_q, out_lt_q, out_gt_q, out_cnt_q;
  logic             out_sat_q;

  logic             w_ready;
  logic             w_beat;
  logic             w_first;
  logic [N-1:0]     w_thr;
  logic             w_lt, w_gt, w_eq;

  assign w_ready = (state_q != S_REPORT);
  assign w_beat  = bus.in_valid & w_ready;
  assign w_first = (state_q == S_IDLE);
  // The first beat of a frame compares against the live threshold.
  assign w_thr   = w_first ? bus.thresh : thr_q;
  assign w_lt    = (bus.in_data < w_thr);
  assign w_gt    = (bus.in_data > w_thr);
  assign w_eq    = ~(w_lt | w_gt);

  always_comb begin
    thr_d = thr_q;
    min_d = min_q;
    max_d = max_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    gt_d  = gt_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (w_beat) begin
      if (w_first) begin
        thr_d = bus.thresh;
        min_d = bus.in_data;
        max_d = bus.in_data;
        eq_d  = w_eq ? c_cnt_one : '0;
        lt_d  = w_lt ? c_cnt_one : '0;
        gt_d  = w_gt ? c_cnt_one : '0;
        cnt_d = c_cnt_one;
        sat_d = 1'b0;
      end else begin
        if (bus.in_data < min_q) min_d = bus.in_data;
        if (bus.in_data > max_q) max_d = bus.in_data;
        // Saturating tallies: a blocked increment flags the frame instead.
        if (w_eq) begin
          if (eq_q == c_cnt_max) sat_d = 1'b1;
          else                   eq_d  = eq_q + c_cnt_one;
        end
        if (w_lt) begin
          if (lt_q == c_cnt_max) sat_d = 1'b1;
          else                   lt_d  = lt_q + c_cnt_one;
        end
        if (w_gt) begin
          if (gt_q == c_cnt_max) sat_d = 1'b1;
          else                   gt_d  = gt_q + c_cnt_one;
        end
        if (cnt_q == c_cnt_max) sat_d = 1'b1;
        else                    cnt_d = cnt_q + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      eq_q        <= '0;
      lt_q        <= '0;
      gt_q        <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_max_q   <= '0;
      out_eq_q    <= '0;
      out_lt_q    <= '0;
      out_gt_q    <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      thr_q <= thr_d;
      min_q <= min_d;
      max_q <= max_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      gt_q  <= gt_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (w_beat) begin
            if (bus.in_last) begin
              // Record registers only move at frame end, so they hold
              // the last result while the next frame accumulates.
              state_q     <= S_REPORT;
              out_valid_q <= 1'b1;
              out_min_q   <= min_d;
              out_max_q   <= max_d;
              out_eq_q    <= eq_d;
              out_lt_q    <= lt_d;
              out_gt_q    <= gt_d;
              out_cnt_q   <= cnt_d;
              out_sat_q   <= sat_d;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_REPORT: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_min    = out_min_q;
  assign bus.out_max    = out_max_q;
  assign bus.out_cnt_eq = out_eq_q;
  assign bus.out_cnt_lt = out_lt_q;
  assign bus.out_cnt_gt = out_gt_q;
  assign bus.out_count  = out_cnt_q;
  assign bus.out_sat    = out_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_frame_stats.sv
// ============================================================================
// Module   : tb_cmp_frame_stats
// Purpose  : Self-checking bench: directed vector table plus random frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_frame_stats;

  localparam int N    = 16;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  typedef logic [19:0][15:0] beats_t;

  typedef struct {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [3:0]  eq;
    logic [3:0]  lt;
    logic [3:0]  gt;
    logic [3:0]  cnt;
    logic        sat;
  } rec_t;

  typedef struct {
    int          nb;
    beats_t      b;
    logic [15:0] th0;
    logic [15:0] th1;
    int          gap;
    rec_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_frame_stats_if #(.N(N), .CNT_W(CW)) bus ();

  cmp_frame_stats #(.N(N), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests = 0;
  int   fails = 0;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rec(input string tag, input rec_t e);
    chk({tag, ".min"}, 32'(bus.out_min),    32'(e.mn));
    chk({tag, ".max"}, 32'(bus.out_max),    32'(e.mx));
    chk({tag, ".eq"},  32'(bus.out_cnt_eq), 32'(e.eq));
    chk({tag, ".lt"},  32'(bus.out_cnt_lt), 32'(e.lt));
    chk({tag, ".gt"},  32'(bus.out_cnt_gt), 32'(e.gt));
    chk({tag, ".cnt"}, 32'(bus.out_count),  32'(e.cnt));
    chk({tag, ".sat"}, 32'(bus.out_sat),    32'(e.sat));
  endtask

  function automatic int clip(input int n);
    return (n > CMAX) ? CMAX : n;
  endfunction

  // Reference: counts by plain tallying over the whole frame, then clipping.
  task automatic model(input logic [15:0] q[$], input logic [15:0] th, output rec_t r);
    int neq = 0, nlt = 0, ngt = 0;
    r.mn = q[0];
    r.mx = q[0];
    foreach (q[i]) begin
      if (q[i] < r.mn) r.mn = q[i];
      if (q[i] > r.mx) r.mx = q[i];
      if (q[i] == th)     neq++;
      else if (q[i] < th) nlt++;
      else                ngt++;
    end
    r.eq  = 4'(clip(neq));
    r.lt  = 4'(clip(nlt));
    r.gt  = 4'(clip(ngt));
    r.cnt = 4'(clip(q.size()));
    r.sat = (q.size() > CMAX);
  endtask

  task automatic drive_frame(input string tag, input logic [15:0] q[$],
                             input logic [15:0] th0, input logic [15:0] th1, input int gap);
    int w;
    for (int i = 0; i < q.size(); i++) begin
      while (int'($urandom_range(99)) < gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_last  = 1'($urandom_range(1));
        bus.thresh   = 16'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      bus.in_last  = (i == q.size() - 1);
      bus.thresh   = (i == 0) ? th0 : th1;
      w = 0;
      while (!bus.in_ready && w < 50) begin
        @(posedge clk); #1;
        w++;
      end
      if (!bus.in_ready) chk({tag, ".ready_timeout"}, 32'(bus.in_ready), 32'd1);
      if (i == q.size() - 1) chk({tag, ".valid_before_last"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk({tag, ".valid_latency"}, 32'(bus.out_valid), 32'd1);
  endtask

  // Stall the record, poke junk beats at the stage, then consume it.
  task automatic hold_and_consume(input string tag, input int hold, input rec_t e);
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'($urandom);
      bus.in_last  = 1'($urandom_range(1));
      bus.thresh   = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(bus.in_ready), 32'd0);
      check_rec({tag, ".hold"}, e);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    check_rec(tag, e);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".keep_min"},   32'(bus.out_min), 32'(e.mn));
  endtask

  task automatic reset_midframe();
    logic [15:0] q[$];
    q = '{16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = q[i];
      bus.in_last  = 1'b0;
      bus.thresh   = 16'd7;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("rst_mid.valid", 32'(bus.out_valid),  32'd0);
    chk("rst_mid.min",   32'(bus.out_min),    32'd0);
    chk("rst_mid.max",   32'(bus.out_max),    32'd0);
    chk("rst_mid.eq",    32'(bus.out_cnt_eq), 32'd0);
    chk("rst_mid.lt",    32'(bus.out_cnt_lt), 32'd0);
    chk("rst_mid.gt",    32'(bus.out_cnt_gt), 32'd0);
    chk("rst_mid.cnt",   32'(bus.out_count),  32'd0);
    chk("rst_mid.sat",   32'(bus.out_sat),    32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] th0, th1, v;
    rec_t        e;
    int          len;

    // Beat lists are packed: the rightmost element is beat 0.
    tbl[0] = '{5, beats_t'({16'd65535, 16'd100, 16'd300, 16'd20, 16'd100}), 16'd100, 16'd100, 0,
               '{16'd20, 16'd65535, 4'd2, 4'd1, 4'd2, 4'd5, 1'b0}};
    tbl[1] = '{1, beats_t'({16'd5}), 16'd5, 16'd5, 0,
               '{16'd5, 16'd5, 4'd1, 4'd0, 4'd0, 4'd1, 1'b0}};
    tbl[2] = '{3, beats_t'({16'd40, 16'd60, 16'd50}), 16'd50, 16'd0, 0,
               '{16'd40, 16'd60, 4'd1, 4'd1, 4'd1, 4'd3, 1'b0}};
    tbl[3] = '{3, beats_t'({16'd7, 16'hFFFF, 16'd0}), 16'd0, 16'd0, 40,
               '{16'd0, 16'hFFFF, 4'd1, 4'd0, 4'd2, 4'd3, 1'b0}};
    tbl[4] = '{20, beats_t'({20{16'd9}}), 16'd9, 16'd9, 0,
               '{16'd9, 16'd9, 4'd15, 4'd0, 4'd0, 4'd15, 1'b1}};
    tbl[5] = '{2, beats_t'({16'd3, 16'd3}), 16'd1, 16'd1, 0,
               '{16'd3, 16'd3, 4'd0, 4'd0, 4'd2, 4'd2, 1'b0}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.thresh    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", 32'(bus.out_valid), 32'd0);
    check_rec("reset", '{16'd0, 16'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("reset.ready", 32'(bus.in_ready), 32'd1);

    for (int k = 0; k < 6; k++) begin
      q = {};
      for (int i = 0; i < tbl[k].nb; i++) q.push_back(tbl[k].b[i]);
      drive_frame($sformatf("vec%0d", k), q, tbl[k].th0, tbl[k].th1, tbl[k].gap);
      hold_and_consume($sformatf("vec%0d", k), (k == 0) ? 10 : int'($urandom_range(3)), tbl[k].e);
      if (k == 0) reset_midframe();
    end

    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(3))
        0:       th0 = 16'd0;
        1:       th0 = 16'hFFFF;
        default: th0 = 16'($urandom_range(200));
      endcase
      th1 = 16'($urandom);
      len = (f % 5 == 0) ? int'($urandom_range(16, 24)) : int'($urandom_range(1, 8));
      q = {};
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(4))
          0:       v = th0;
          1:       v = 16'd0;
          2:       v = 16'hFFFF;
          3:       v = 16'($urandom_range(200));
          default: v = 16'($urandom);
        endcase
        q.push_back(v);
      end
      model(q, th0, e);
      drive_frame($sformatf("rnd%0d", f), q, th0, th1, 25);
      hold_and_consume($sformatf("rnd%0d", f), int'($urandom_range(3)), e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
